// File: rtl/sync_down_counter.sv
// Loadable down-counter with IDLE/COUNT/DONE control: counts from a start
// value to zero, pulses done for one cycle, and can reload, hold or abort.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
    end
  end

  // Handshake: start is a level request with an implicit ready of (state ==
  // IDLE); it is taken on any edge where both hold, and ignored otherwise.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    case (state)
      IDLE: begin
        if (start) begin
          q_nxt      = load_val;
          reload_nxt = load_val;
          state_nxt  = (load_val == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end else if (!hold) begin
          // A zero count here would be unreachable; saturate rather than wrap.
          if (q == '0) begin
            state_nxt = DONE;
          end else begin
            q_nxt = q - ONE;
            if (q == ONE) state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end else if (auto_reload) begin
          q_nxt     = reload;
          state_nxt = (reload == '0) ? DONE : COUNT;
        end else begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        q_nxt     = '0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign tc        = (q == '0);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: a behavioural run model checked every
// cycle, plus literal expectations for each scenario.
module tb_sync_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic         hold;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  sync_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .hold(hold), .abort(abort),
    .q(q), .busy(busy), .tc(tc), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a run is either absent, counting down the remaining
  // value, or sitting in its single completion cycle.
  int m_q      = 0;
  int m_reload = 0;
  bit m_active = 0;
  bit m_finish = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q = 0; m_reload = 0; m_active = 0; m_finish = 0;
    end else if (!m_active) begin
      if (start) begin
        m_reload = int'(load_val);
        m_q      = m_reload;
        m_active = 1;
        m_finish = (m_q == 0);
      end
    end else if (abort) begin
      m_active = 0; m_finish = 0; m_q = 0;
    end else if (m_finish) begin
      if (auto_reload) begin
        m_q      = m_reload;
        m_finish = (m_q == 0);
      end else begin
        m_active = 0; m_finish = 0; m_q = 0;
      end
    end else if (!hold) begin
      if (m_q > 0) m_q = m_q - 1;
      m_finish = (m_q == 0);
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // scoreboard compare, every cycle outside reset
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_q",    int'(q),    m_q);
      chk("model_busy", int'(busy), int'(m_active));
      chk("model_tc",   int'(tc),   int'(m_q == 0));
      chk("model_done", int'(done), int'(m_finish));
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start(input int v);
    load_val = W'(v);
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic run_out(input string name, input int expect_cycles);
    int n;
    n = 0;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    chk(name, n, expect_cycles);
  endtask

  int lat;

  initial begin
    reset = 1'b1; start = 0; load_val = '0; auto_reload = 0; hold = 0; abort = 0;
    repeat (2) @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tc", int'(tc), 1);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    cyc();

    // 3,2,1,0 then idle
    do_start(3);
    exp_q = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 4; i++) begin
      chk("seq3_q", int'(q), int'(exp_q.pop_front()));
      chk("seq3_done", int'(done), int'(i == 3));
      if (i < 3) cyc();
    end
    chk("seq3_tc", int'(tc), 1);
    cyc();
    chk("seq3_idle", int'(busy), 0);

    // hold two cycles at q=3, done 7 edges after start
    do_start(5);
    lat = 0;
    cyc(); lat++;
    cyc(); lat++;
    chk("hold_pre", int'(q), 3);
    hold = 1'b1;
    cyc(); lat++;
    chk("hold_1", int'(q), 3);
    cyc(); lat++;
    chk("hold_2", int'(q), 3);
    hold = 1'b0;
    while (!done && lat < 40) begin
      cyc();
      lat++;
    end
    chk("hold_latency", lat, 7);
    cyc();

    // auto reload 2,1,0,2,1,0
    auto_reload = 1'b1;
    do_start(2);
    exp_q = {4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 6; i++) begin
      chk("reload_q", int'(q), int'(exp_q.pop_front()));
      chk("reload_done", int'(done), int'(i % 3 == 2));
      if (i == 5) auto_reload = 1'b0;
      cyc();
    end
    chk("reload_stop_busy", int'(busy), 0);
    chk("reload_stop_q", int'(q), 0);

    // abort outranks hold and start
    do_start(6);
    cyc(); cyc();
    chk("abort_pre", int'(q), 4);
    hold = 1'b1; start = 1'b1; abort = 1'b1; load_val = 4'd9;
    cyc();
    hold = 1'b0; start = 1'b0; abort = 1'b0;
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    do_start(2);
    chk("after_abort_start", int'(q), 2);
    run_out("after_abort_run", 2);
    cyc();

    // abort in DONE beats auto_reload
    do_start(1);
    cyc();
    chk("abort_done_pre", int'(done), 1);
    abort = 1'b1; auto_reload = 1'b1;
    cyc();
    abort = 1'b0; auto_reload = 1'b0;
    chk("abort_in_done_busy", int'(busy), 0);

    // start while busy ignored; reload value kept
    do_start(4);
    start = 1'b1; load_val = 4'd9;
    cyc();
    start = 1'b0;
    chk("busy_start_ignored", int'(q), 3);
    run_out("busy_start_run", 3);
    auto_reload = 1'b1;
    cyc();
    chk("reload_kept", int'(q), 4);
    auto_reload = 1'b0; abort = 1'b1;
    cyc();
    abort = 1'b0;

    // abort in IDLE is harmless; start accepted
    abort = 1'b1; start = 1'b1; load_val = 4'd2;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_start", int'(q), 2);
    run_out("idle_abort_run", 2);
    // hold during DONE ignored
    hold = 1'b1;
    cyc();
    hold = 1'b0;
    chk("hold_in_done", int'(busy), 0);

    // zero load, full-range load
    do_start(0);
    chk("zero_done", int'(done), 1);
    chk("zero_q", int'(q), 0);
    cyc();
    chk("zero_idle", int'(busy), 0);
    do_start(15);
    chk("full_q", int'(q), 15);
    run_out("full_latency", 15);
    cyc();
    chk("full_nowrap", int'(q), 0);

    // asynchronous reset mid-count
    do_start(9);
    cyc(); cyc(); cyc();
    chk("rst_mid_pre", int'(q), 6);
    #2 reset = 1'b1;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tc", int'(tc), 1);
    chk("arst_done", int'(done), 0);
    #1 reset = 1'b0;
    cyc();
    chk("arst_after_busy", int'(busy), 0);
    chk("arst_after_done", int'(done), 0);
    cyc();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
